// File: rtl/cnn_pkg.sv
// Shared defaults and helpers for the CNN pooling datapath.
package cnn_pkg;

  localparam int PP      = 8;
  localparam int DIM     = 10;
  localparam int OUT_DIM = DIM / 2;

  // Wide signed carrier so smax serves any pixel width up to 32 bits.
  typedef logic signed [31:0] word_t;

  function automatic word_t smax(input word_t a, input word_t b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pool_line_buf.sv
// Half-row buffer of horizontal pair maxima; sync write, combinational read.
module pool_line_buf #(
  parameter int PP    = cnn_pkg::PP,
  parameter int DEPTH = cnn_pkg::OUT_DIM,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [AW-1:0]        addr,
  input  logic signed [PP:0]   wdata,
  output logic signed [PP:0]   rdata
);

  logic signed [PP:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/max_pool_2x2_stream.sv
// Streaming 2x2 stride-2 signed max-pool over one raster-order feature map.
module max_pool_2x2_stream #(
  parameter int PP  = cnn_pkg::PP,
  parameter int DIM = cnn_pkg::DIM
) (
  input  logic               clk,
  input  logic               reset,
  input  logic signed [PP:0] pxl_in,
  input  logic               in_valid,
  output logic signed [PP:0] pool_out,
  output logic               out_valid,
  output logic               frame_done
);
  import cnn_pkg::*;

  localparam int OUT_DIM = DIM / 2;
  localparam int CW      = (DIM > 1) ? $clog2(DIM) : 1;
  localparam int AW      = (OUT_DIM > 1) ? $clog2(OUT_DIM) : 1;

  typedef logic [CW-1:0]      cnt_t;
  typedef logic signed [PP:0] pix_t;

  localparam cnt_t LAST      = cnt_t'(DIM - 1);
  localparam cnt_t SPAN_LAST = cnt_t'(2 * OUT_DIM - 1);

  cnt_t          col;
  cnt_t          row;
  pix_t          h_reg;
  pix_t          h_max;
  pix_t          win_max;
  pix_t          lb_rdata;
  logic [AW-1:0] lb_addr;
  logic          in_win;
  logic          lb_we;

  // Odd DIM: the trailing row/column falls outside every window.
  always_comb begin
    in_win  = (col <= SPAN_LAST) && (row <= SPAN_LAST);
    lb_addr = AW'(col >> 1);
    h_max   = pix_t'(smax(word_t'(h_reg), word_t'(pxl_in)));
    win_max = pix_t'(smax(word_t'(lb_rdata), word_t'(h_max)));
    lb_we   = in_valid && in_win && col[0] && !row[0];
  end

  pool_line_buf #(
    .PP    (PP),
    .DEPTH (OUT_DIM),
    .AW    (AW)
  ) u_line_buf (
    .clk   (clk),
    .we    (lb_we),
    .addr  (lb_addr),
    .wdata (h_max),
    .rdata (lb_rdata)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col        <= '0;
      row        <= '0;
      h_reg      <= '0;
      pool_out   <= '0;
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
      if (in_valid) begin
        if (col == LAST) begin
          col <= '0;
          row <= (row == LAST) ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
        if (in_win) begin
          if (!col[0]) begin
            h_reg <= pxl_in;
          end else if (row[0]) begin
            pool_out   <= win_max;
            out_valid  <= 1'b1;
            frame_done <= (col == SPAN_LAST) && (row == SPAN_LAST);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_max_pool_2x2_stream.sv
// Self-checking bench for max_pool_2x2_stream at DIM=10 and DIM=11.
module tb_max_pool_2x2_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset;
  logic signed [8:0] pxl10, pxl11, pool10, pool11;
  logic              v10, v11, ov10, ov11, fd10, fd11;

  max_pool_2x2_stream #(.PP(8), .DIM(10)) dut10 (
    .clk(clk), .reset(reset), .pxl_in(pxl10), .in_valid(v10),
    .pool_out(pool10), .out_valid(ov10), .frame_done(fd10)
  );

  max_pool_2x2_stream #(.PP(8), .DIM(11)) dut11 (
    .clk(clk), .reset(reset), .pxl_in(pxl11), .in_valid(v11),
    .pool_out(pool11), .out_valid(ov11), .frame_done(fd11)
  );

  int img [11][11];
  int obs10[$], obs11[$];
  bit dn10[$], dn11[$];
  int exp_q[$];
  bit exp_d[$];
  int stray_done = 0;
  int n_checks = 0;
  int n_fail = 0;

  always @(negedge clk) begin
    if (ov10) begin obs10.push_back(int'(pool10)); dn10.push_back(fd10); end
    else if (fd10) stray_done++;
    if (ov11) begin obs11.push_back(int'(pool11)); dn11.push_back(fd11); end
    else if (fd11) stray_done++;
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  task automatic fill_ramp(input int dim, input int sign);
    for (int r = 0; r < dim; r++)
      for (int c = 0; c < dim; c++)
        img[r][c] = sign * (dim * r + c);
  endtask

  task automatic fill_const(input int val);
    for (int r = 0; r < 11; r++)
      for (int c = 0; c < 11; c++)
        img[r][c] = val;
  endtask

  // Drives up to npix pixels in raster order; duty<100 inserts random idle cycles.
  task automatic drive_frame(input int dim, input int duty, input int npix);
    int k;
    k = 0;
    for (int r = 0; r < dim; r++) begin
      for (int c = 0; c < dim; c++) begin
        if (k < npix) begin
          while (duty < 100 && $urandom_range(99) >= duty) begin
            v10 = 1'b0; v11 = 1'b0;
            @(negedge clk);
          end
          if (dim == 10) begin pxl10 = img[r][c][8:0]; v10 = 1'b1; end
          else           begin pxl11 = img[r][c][8:0]; v11 = 1'b1; end
          @(negedge clk);
          k++;
        end
      end
    end
  endtask

  task automatic idle(input int n);
    v10 = 1'b0; v11 = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic add_expected(input int dim);
    int h;
    h = dim / 2;
    for (int i = 0; i < h; i++)
      for (int j = 0; j < h; j++) begin
        exp_q.push_back(max4(img[2*i][2*j], img[2*i][2*j+1],
                             img[2*i+1][2*j], img[2*i+1][2*j+1]));
        exp_d.push_back(i == h - 1 && j == h - 1);
      end
  endtask

  task automatic clear_obs();
    obs10.delete(); obs11.delete(); dn10.delete(); dn11.delete();
  endtask

  task automatic check_outputs(input int dim, input string tag);
    int n;
    n = (dim == 10) ? obs10.size() : obs11.size();
    check({tag, ".count"}, n, exp_q.size());
    for (int k = 0; k < exp_q.size() && k < n; k++) begin
      if (dim == 10) begin
        check($sformatf("%s.val[%0d]", tag, k), obs10[k], exp_q[k]);
        check($sformatf("%s.done[%0d]", tag, k), int'(dn10[k]), int'(exp_d[k]));
      end else begin
        check($sformatf("%s.val[%0d]", tag, k), obs11[k], exp_q[k]);
        check($sformatf("%s.done[%0d]", tag, k), int'(dn11[k]), int'(exp_d[k]));
      end
    end
    exp_q.delete(); exp_d.delete();
    clear_obs();
  endtask

  initial begin
    reset = 1'b1;
    v10 = 1'b0; v11 = 1'b0; pxl10 = '0; pxl11 = '0;
    repeat (3) @(negedge clk);
    check("reset.pool_out", int'(pool10), 0);
    check("reset.out_valid", int'(ov10), 0);
    check("reset.frame_done", int'(fd10), 0);
    check("reset.out_valid11", int'(ov11), 0);
    reset = 1'b0;
    idle(2);

    fill_ramp(10, 1);
    drive_frame(10, 100, 100);
    idle(3);
    add_expected(10);
    check_outputs(10, "ramp");

    fill_const(-256);
    drive_frame(10, 100, 100);
    idle(3);
    add_expected(10);
    check_outputs(10, "neg256");

    fill_const(-1);
    img[3][5] = 127;
    drive_frame(10, 100, 100);
    idle(3);
    add_expected(10);
    check("hot.model_idx7", exp_q[7], 127);
    check_outputs(10, "hot");

    fill_ramp(10, 1);
    drive_frame(10, 40, 100);
    idle(3);
    add_expected(10);
    check_outputs(10, "gaps");

    drive_frame(10, 100, 37);
    v10 = 1'b0;
    clear_obs();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("midrst.pool_out", int'(pool10), 0);
    check("midrst.out_valid", int'(ov10), 0);
    reset = 1'b0;
    idle(3);
    check("midrst.no_pulse", obs10.size(), 0);
    drive_frame(10, 100, 100);
    idle(3);
    add_expected(10);
    check_outputs(10, "after_rst");

    fill_ramp(10, 1);
    drive_frame(10, 100, 100);
    add_expected(10);
    fill_ramp(10, -1);
    drive_frame(10, 100, 100);
    add_expected(10);
    idle(3);
    check_outputs(10, "b2b");

    fill_ramp(11, 1);
    drive_frame(11, 100, 121);
    idle(3);
    add_expected(11);
    check("dim11.model_first", exp_q[0], 12);
    check_outputs(11, "dim11");

    check("stray_frame_done", stray_done, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
